// File: rtl/data_sram_pkg.sv
// Shared constants and helpers for the data SRAM responder: config window
// select value, config register offsets and the byte-lane merge used by
// every byte-enabled register.
package data_sram_pkg;

    localparam logic [15:0] CONF_HI_DEF = 16'hbfaf;

    localparam logic [15:0] LED_OFF     = 16'hf000;
    localparam logic [15:0] NUM_OFF     = 16'hf010;
    localparam logic [15:0] SW_OFF      = 16'hf020;
    localparam logic [15:0] TIMER_OFF   = 16'he000;
    localparam logic [15:0] SCRATCH_OFF = 16'hf030;

    // Replace each byte of old_v whose enable bit is set with the same byte of new_v.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_sram_responder_be_ram.sv
// Byte-enable synchronous RAM with a registered read port. The read register
// only moves on a read strobe, so it holds its value across writes and idles.
module be_ram
    import data_sram_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RAM_INIT = 32'h0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_idx,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Storage array plus read register; every word returns to RAM_INIT on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= RAM_INIT;
            r_rdata <= 32'h0;
        end else begin
            if (i_we) r_mem[i_idx] <= merge_bytes(r_mem[i_idx], i_wdata, i_be);
            if (i_re) r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_sram_responder.sv
// Slave side of the CPU data SRAM port. Decodes each request into either the
// word RAM or the config register window (LED, NUM, switches, timer, scratch)
// and returns read data one cycle after the read edge.
module data_sram_responder
    import data_sram_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [15:0] CONF_HI  = CONF_HI_DEF,
    parameter logic [31:0] RAM_INIT = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led_out,
    output logic [31:0] num_out
);

    logic              w_cfg_sel;
    logic [15:0]       w_off;
    logic              w_wr;
    logic              w_rd;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_ram_rdata;
    logic [31:0]       w_cfg_rdata;
    logic [31:0]       w_timer_inc;

    logic [15:0]       r_led;
    logic [31:0]       r_num;
    logic [31:0]       r_scratch;
    logic [31:0]       r_timer;
    logic [7:0]        r_sw_meta;
    logic [7:0]        r_sw_sync;
    logic [31:0]       r_cfg_rdata;
    logic              r_rd_cfg;

    assign w_cfg_sel   = (data_sram_addr[31:16] == CONF_HI);
    assign w_off       = data_sram_addr[15:0];
    assign w_wr        = data_sram_en && (data_sram_wen != 4'h0);
    assign w_rd        = data_sram_en && (data_sram_wen == 4'h0);
    assign w_idx       = data_sram_addr[ADDR_W+1:2];
    assign w_timer_inc = r_timer + 32'd1;

    be_ram #(
        .ADDR_W   (ADDR_W),
        .RAM_INIT (RAM_INIT)
    ) u_ram (
        .clk     (clk),
        .resetn  (resetn),
        .i_we    (w_wr && !w_cfg_sel),
        .i_re    (w_rd && !w_cfg_sel),
        .i_be    (data_sram_wen),
        .i_idx   (w_idx),
        .i_wdata (data_sram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Config read mux; unmapped offsets read as zero. Timer returns its pre-edge value.
    always_comb begin
        w_cfg_rdata = 32'h0;
        case (w_off)
            LED_OFF:     w_cfg_rdata = {16'h0, r_led};
            NUM_OFF:     w_cfg_rdata = r_num;
            SW_OFF:      w_cfg_rdata = {24'h0, r_sw_sync};
            TIMER_OFF:   w_cfg_rdata = r_timer;
            SCRATCH_OFF: w_cfg_rdata = r_scratch;
            default:     w_cfg_rdata = 32'h0;
        endcase
    end

    // Writable config registers; writes to unmapped or read-only offsets are dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_led     <= 16'hffff;
            r_num     <= 32'h0;
            r_scratch <= 32'h0;
        end else if (w_wr && w_cfg_sel) begin
            if (w_off == LED_OFF) begin
                if (data_sram_wen[0]) r_led[7:0]  <= data_sram_wdata[7:0];
                if (data_sram_wen[1]) r_led[15:8] <= data_sram_wdata[15:8];
            end
            if (w_off == NUM_OFF)     r_num     <= merge_bytes(r_num, data_sram_wdata, data_sram_wen);
            if (w_off == SCRATCH_OFF) r_scratch <= merge_bytes(r_scratch, data_sram_wdata, data_sram_wen);
        end
    end

    // Free-running timer; a write replaces only the enabled bytes of the incremented value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timer <= 32'h0;
        end else if (w_wr && w_cfg_sel && (w_off == TIMER_OFF)) begin
            r_timer <= merge_bytes(w_timer_inc, data_sram_wdata, data_sram_wen);
        end else begin
            r_timer <= w_timer_inc;
        end
    end

    // Two-flop synchronizer for the asynchronous board switches.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sw_meta <= 8'h0;
            r_sw_sync <= 8'h0;
        end else begin
            r_sw_meta <= switch_in;
            r_sw_sync <= r_sw_meta;
        end
    end

    // Config read capture and source select; both only move on a read so rdata holds otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cfg_rdata <= 32'h0;
            r_rd_cfg    <= 1'b0;
        end else if (w_rd) begin
            r_rd_cfg <= w_cfg_sel;
            if (w_cfg_sel) r_cfg_rdata <= w_cfg_rdata;
        end
    end

    assign data_sram_rdata = r_rd_cfg ? r_cfg_rdata : w_ram_rdata;
    assign led_out         = r_led;
    assign num_out         = r_num;

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized self-checking bench for data_sram_responder with a
// transaction-level reference model of the RAM and config window.
module tb_data_sram_responder;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  sw;
    logic [15:0] led;
    logic [31:0] num;

    int vectors;
    int miscompares;

    // reference model state
    logic [31:0] m_ram [1024];
    logic [15:0] m_led;
    logic [31:0] m_num;
    logic [31:0] m_scratch;
    logic [31:0] m_timer;
    logic [31:0] m_rdata;
    logic [7:0]  m_sw_hist [2];   // [0] sampled last edge, [1] sampled two edges ago

    data_sram_responder dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .switch_in       (sw),
        .led_out         (led),
        .num_out         (num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) m_ram[i] = 32'h0;
        m_led = 16'hffff; m_num = 0; m_scratch = 0; m_timer = 0; m_rdata = 0;
        m_sw_hist[0] = 0; m_sw_hist[1] = 0;
    endtask

    // One bus cycle: drive, take the edge, advance the model, settle 1ns past the edge.
    task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        logic        cfg;
        logic [15:0] off;
        logic [31:0] tnext;
        en = e; wen = w; addr = a; wdata = d;
        @(posedge clk);
        cfg   = (a[31:16] == 16'hbfaf);
        off   = a[15:0];
        tnext = m_timer + 1;
        if (e && w == 4'h0) begin
            if (!cfg) m_rdata = m_ram[a[11:2]];
            else case (off)
                16'hf000: m_rdata = {16'h0, m_led};
                16'hf010: m_rdata = m_num;
                16'hf020: m_rdata = {24'h0, m_sw_hist[1]};
                16'he000: m_rdata = m_timer;
                16'hf030: m_rdata = m_scratch;
                default:  m_rdata = 0;
            endcase
        end
        if (e && w != 4'h0) begin
            if (!cfg) m_ram[a[11:2]] = mrg(m_ram[a[11:2]], d, w);
            else case (off)
                16'hf000: m_led = mrg({16'h0, m_led}, d, {2'b00, w[1:0]}) & 32'hffff;
                16'hf010: m_num = mrg(m_num, d, w);
                16'he000: tnext = mrg(tnext, d, w);
                16'hf030: m_scratch = mrg(m_scratch, d, w);
                default: ;
            endcase
        end
        m_timer = tnext;
        m_sw_hist[1] = m_sw_hist[0];
        m_sw_hist[0] = sw;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        resetn = 1'b0; en = 0; wen = 0; addr = 0; wdata = 0; sw = 0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        vectors++;
        if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h want %h", rdata, 32'h0); end
        vectors++;
        if (led !== 16'hffff) begin miscompares++; $display("FAIL reset_led got %h want %h", led, 16'hffff); end
        vectors++;
        if (num !== 32'h0) begin miscompares++; $display("FAIL reset_num got %h want %h", num, 32'h0); end
        @(negedge clk);
        resetn = 1'b1;
        step(1'b1, 4'h0, 32'hbfafe000, 0);
        vectors++;
        if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_timer_first got %h want %h", rdata, 32'h0); end
        step(1'b1, 4'h0, 32'hbfafe000, 0);
        vectors++;
        if (rdata !== 32'h1) begin miscompares++; $display("FAIL reset_timer_second got %h want %h", rdata, 32'h1); end
    endtask

    task automatic test_ram_rw();
        step(1'b1, 4'hf, 32'h10, 32'hdeadbeef);
        step(1'b1, 4'h0, 32'h10, 0);
        vectors++;
        if (rdata !== 32'hdeadbeef) begin miscompares++; $display("FAIL ram_read got %h want %h", rdata, 32'hdeadbeef); end
        for (int i = 0; i < 2; i++) begin
            idle();
            vectors++;
            if (rdata !== 32'hdeadbeef) begin miscompares++; $display("FAIL ram_hold%0d got %h want %h", i, rdata, 32'hdeadbeef); end
        end
        step(1'b1, 4'hf, 32'h20, 32'h12345678);
        vectors++;
        if (rdata !== 32'hdeadbeef) begin miscompares++; $display("FAIL ram_hold_on_write got %h want %h", rdata, 32'hdeadbeef); end
    endtask

    task automatic test_byte_enables();
        step(1'b1, 4'b0101, 32'h10, 32'h11223344);
        step(1'b1, 4'h0, 32'h10, 0);
        vectors++;
        if (rdata !== 32'hde22be44) begin miscompares++; $display("FAIL byte_en got %h want %h", rdata, 32'hde22be44); end
        step(1'b0, 4'hf, 32'h10, 32'h0);
        step(1'b1, 4'h0, 32'h10, 0);
        vectors++;
        if (rdata !== 32'hde22be44) begin miscompares++; $display("FAIL en_low_write got %h want %h", rdata, 32'hde22be44); end
    endtask

    task automatic test_wrap();
        step(1'b1, 4'hf, 32'h00001000, 32'h5);
        step(1'b1, 4'h0, 32'h0, 0);
        vectors++;
        if (rdata !== 32'h5) begin miscompares++; $display("FAIL wrap got %h want %h", rdata, 32'h5); end
        step(1'b1, 4'h0, 32'h13, 0);
        vectors++;
        if (rdata !== 32'hde22be44) begin miscompares++; $display("FAIL addr_lsb_ignored got %h want %h", rdata, 32'hde22be44); end
    endtask

    task automatic test_config();
        step(1'b1, 4'hf, 32'hbfaff000, 32'h0000a5a5);
        vectors++;
        if (led !== 16'ha5a5) begin miscompares++; $display("FAIL led got %h want %h", led, 16'ha5a5); end
        for (int i = 0; i < 3; i++) begin
            logic [31:0] v;
            v = $urandom;
            step(1'b1, 4'hf, 32'hbfaff010, v);
            vectors++;
            if (num !== v) begin miscompares++; $display("FAIL num%0d got %h want %h", i, num, v); end
        end
        sw = 8'h3c;
        idle(); idle();
        step(1'b1, 4'h0, 32'hbfaff020, 0);
        vectors++;
        if (rdata !== 32'h3c) begin miscompares++; $display("FAIL switch got %h want %h", rdata, 32'h3c); end
        step(1'b1, 4'hf, 32'hbfaff030, 32'hcafef00d);
        step(1'b1, 4'h0, 32'hbfaff030, 0);
        vectors++;
        if (rdata !== 32'hcafef00d) begin miscompares++; $display("FAIL scratch got %h want %h", rdata, 32'hcafef00d); end
        step(1'b1, 4'h0, 32'hbfaff0ff, 0);
        vectors++;
        if (rdata !== 32'h0) begin miscompares++; $display("FAIL unmapped got %h want %h", rdata, 32'h0); end
    endtask

    task automatic test_timer();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'hfffffffe; exp_seq[1] = 32'hffffffff; exp_seq[2] = 32'h0;
        step(1'b1, 4'hf, 32'hbfafe000, 32'hfffffffe);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'h0, 32'hbfafe000, 0);
            vectors++;
            if (rdata !== exp_seq[i]) begin miscompares++; $display("FAIL timer_wrap%0d got %h want %h", i, rdata, exp_seq[i]); end
        end
        step(1'b1, 4'hf, 32'hbfafe000, 32'h000000ff);
        idle();
        step(1'b1, 4'b0001, 32'hbfafe000, 32'h00000077);
        step(1'b1, 4'h0, 32'hbfafe000, 0);
        vectors++;
        if (rdata !== 32'h00000177) begin miscompares++; $display("FAIL timer_partial got %h want %h", rdata, 32'h00000177); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, d;
            a = {20'h0, $urandom_range(0, 4095)} & 32'hffc;
            d = $urandom;
            step(1'b1, 4'hf, a, d);
            step(1'b1, 4'h0, a, 0);
            vectors++;
            if (rdata !== d) begin miscompares++; $display("FAIL b2b%0d addr %h got %h want %h", i, a, rdata, d); end
        end
    endtask

    task automatic test_random();
        logic [15:0] offs [6];
        offs[0] = 16'hf000; offs[1] = 16'hf010; offs[2] = 16'hf020;
        offs[3] = 16'he000; offs[4] = 16'hf030; offs[5] = 16'hf044;
        for (int i = 0; i < 400; i++) begin
            logic        e;
            logic [3:0]  w;
            logic [31:0] a;
            e = ($urandom_range(0, 5) != 0);
            w = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
            if ($urandom_range(0, 3) == 0) a = {16'hbfaf, offs[$urandom_range(0, 5)]};
            else a = {$urandom_range(0, 65535), 4'h0, 12'($urandom_range(0, 63))} & 32'h7fffffff;
            if ($urandom_range(0, 9) == 0) sw = 8'($urandom);
            step(e, w, a, $urandom);
            vectors++;
            if (rdata !== m_rdata) begin miscompares++; $display("FAIL rand%0d rdata got %h want %h", i, rdata, m_rdata); end
            vectors++;
            if (led !== m_led || num !== m_num) begin
                miscompares++;
                $display("FAIL rand%0d led/num got %h/%h want %h/%h", i, led, num, m_led, m_num);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) step(1'b1, 4'hf, 32'h40 + 32'(4*i), 32'h1000 + 32'(i));
        step(1'b1, 4'hf, 32'hbfaff010, 32'h87654321);
        step(1'b1, 4'h0, 32'h40, 0);
        en = 1'b1; wen = 4'hf; addr = 32'h50; wdata = 32'h99;
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (rdata !== 32'h0) begin miscompares++; $display("FAIL midrst_rdata got %h want %h", rdata, 32'h0); end
        vectors++;
        if (led !== 16'hffff) begin miscompares++; $display("FAIL midrst_led got %h want %h", led, 16'hffff); end
        vectors++;
        if (num !== 32'h0) begin miscompares++; $display("FAIL midrst_num got %h want %h", num, 32'h0); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        step(1'b1, 4'h0, 32'hbfafe000, 0);
        vectors++;
        if (rdata !== 32'h0) begin miscompares++; $display("FAIL midrst_timer got %h want %h", rdata, 32'h0); end
        step(1'b1, 4'h0, 32'h40, 0);
        vectors++;
        if (rdata !== 32'h0) begin miscompares++; $display("FAIL midrst_ram got %h want %h", rdata, 32'h0); end
        step(1'b1, 4'h0, 32'hbfafe000, 0);
        vectors++;
        if (rdata !== 32'h2) begin miscompares++; $display("FAIL midrst_timer_count got %h want %h", rdata, 32'h2); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_ram_rw();
        test_byte_enables();
        test_wrap();
        test_config();
        test_timer();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
